// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the multi-domain power sequencer.
// State encodings are fixed because the packed state bus is observed by software.
package pwr_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PWR_OFF     = 3'd0,
        PWR_RAMP    = 3'd1,
        PWR_RESTORE = 3'd2,
        PWR_ON      = 3'd3,
        PWR_ISO     = 3'd4,
        PWR_SAVE    = 3'd5
    } pwr_state_e;

    // Ramp counter must hold RAMP_CYC-1 and still leave room for the zero test.
    function automatic int ramp_cnt_w(input int ramp_cyc);
        return $clog2(ramp_cyc) + 1;
    endfunction

endpackage

// File: rtl/pwr_seq_ctrl_if.sv
// Bundle between the low-power controller and the sequencer: per-domain
// requests/enables in, switch/isolation/retention controls and status out.
interface pwr_seq_ctrl_if #(
    parameter int NUM_DOM = 2,
    parameter int WIDTH   = 8
);
    import pwr_seq_pkg::*;

    logic [NUM_DOM-1:0]         pwr_req;
    logic [NUM_DOM-1:0]         cnt_en;
    logic [NUM_DOM-1:0]         pwr_en;
    logic [NUM_DOM-1:0]         iso_en;
    logic [NUM_DOM-1:0]         save;
    logic [NUM_DOM-1:0]         restore;
    logic [NUM_DOM-1:0]         pwr_ack;
    logic [NUM_DOM*STATE_W-1:0] state;
    logic [NUM_DOM*WIDTH-1:0]   data;

    modport master (
        output pwr_req,
        output cnt_en,
        input  pwr_en,
        input  iso_en,
        input  save,
        input  restore,
        input  pwr_ack,
        input  state,
        input  data
    );

    modport slave (
        input  pwr_req,
        input  cnt_en,
        output pwr_en,
        output iso_en,
        output save,
        output restore,
        output pwr_ack,
        output state,
        output data
    );

endinterface

// File: rtl/pwr_domain_fsm.sv
// One switchable domain: power sequencing FSM, supply ramp timer, activity
// counter and its retention shadow, plus output decode.
module pwr_domain_fsm
    import pwr_seq_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               RAMP_CYC = 4,
    parameter logic [WIDTH-1:0] ISO_VAL  = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwr_req,
    input  logic               cnt_en,
    output logic               pwr_en,
    output logic               iso_en,
    output logic               save,
    output logic               restore,
    output logic               pwr_ack,
    output logic [STATE_W-1:0] state,
    output logic [WIDTH-1:0]   data
);

    localparam int RC_W = ramp_cnt_w(RAMP_CYC);

    localparam logic [STATE_W-1:0] S_OFF     = PWR_OFF;
    localparam logic [STATE_W-1:0] S_RAMP    = PWR_RAMP;
    localparam logic [STATE_W-1:0] S_RESTORE = PWR_RESTORE;
    localparam logic [STATE_W-1:0] S_ON      = PWR_ON;
    localparam logic [STATE_W-1:0] S_ISO     = PWR_ISO;
    localparam logic [STATE_W-1:0] S_SAVE    = PWR_SAVE;

    localparam logic [RC_W-1:0] RAMP_LOAD = RC_W'(RAMP_CYC - 1);

    logic [STATE_W-1:0] state_reg;
    logic [STATE_W-1:0] state_next;
    logic [RC_W-1:0]    ramp_cnt_reg;
    logic [RC_W-1:0]    ramp_cnt_next;
    logic [WIDTH-1:0]   live_reg;
    logic [WIDTH-1:0]   live_next;
    logic [WIDTH-1:0]   ret_reg;
    logic [WIDTH-1:0]   ret_next;

    // Power sequences run to completion; the request is only looked at in OFF and ON.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_OFF:     if (pwr_req) state_next = S_RAMP;
            S_RAMP:    if (ramp_cnt_reg == '0) state_next = S_RESTORE;
            S_RESTORE: state_next = S_ON;
            S_ON:      if (!pwr_req) state_next = S_ISO;
            S_ISO:     state_next = S_SAVE;
            S_SAVE:    state_next = S_OFF;
            default:   state_next = S_OFF;
        endcase
    end

    always_comb begin
        ramp_cnt_next = ramp_cnt_reg;
        if (state_reg == S_OFF && state_next == S_RAMP) begin
            ramp_cnt_next = RAMP_LOAD;
        end else if (state_reg == S_RAMP && ramp_cnt_reg != '0) begin
            ramp_cnt_next = ramp_cnt_reg - 1'b1;
        end
    end

    // Leaving SAVE captures the live count and then trashes it, as a real
    // power loss would; leaving RESTORE brings the captured value back.
    always_comb begin
        live_next = live_reg;
        ret_next  = ret_reg;
        case (state_reg)
            S_ON:      if (cnt_en) live_next = live_reg + 1'b1;
            S_RESTORE: live_next = ret_reg;
            S_SAVE: begin
                ret_next  = live_reg;
                live_next = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_OFF;
            ramp_cnt_reg <= '0;
            live_reg     <= '1;
            ret_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            ramp_cnt_reg <= ramp_cnt_next;
            live_reg     <= live_next;
            ret_reg      <= ret_next;
        end
    end

    assign pwr_en  = (state_reg != S_OFF);
    assign iso_en  = (state_reg != S_ON);
    assign save    = (state_reg == S_SAVE);
    assign restore = (state_reg == S_RESTORE);
    assign pwr_ack = (state_reg == S_ON);
    assign state   = state_reg;
    assign data    = iso_en ? ISO_VAL : live_reg;

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Multi-domain power sequencer with state retention: NUM_DOM independent
// domain sequencers packed onto the controller interface.
module pwr_seq_ctrl
    import pwr_seq_pkg::*;
#(
    parameter int               NUM_DOM  = 2,
    parameter int               WIDTH    = 8,
    parameter int               RAMP_CYC = 4,
    parameter logic [WIDTH-1:0] ISO_VAL  = '0
) (
    input  logic         clk,
    input  logic         rst,
    pwr_seq_ctrl_if.slave bus
);

    logic [NUM_DOM-1:0]         pwr_en_w;
    logic [NUM_DOM-1:0]         iso_en_w;
    logic [NUM_DOM-1:0]         save_w;
    logic [NUM_DOM-1:0]         restore_w;
    logic [NUM_DOM-1:0]         pwr_ack_w;
    logic [NUM_DOM*STATE_W-1:0] state_w;
    logic [NUM_DOM*WIDTH-1:0]   data_w;

    // Domains share nothing but the clock and reset.
    generate
        for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_dom
            pwr_domain_fsm #(
                .WIDTH    (WIDTH),
                .RAMP_CYC (RAMP_CYC),
                .ISO_VAL  (ISO_VAL)
            ) u_dom (
                .clk     (clk),
                .rst     (rst),
                .pwr_req (bus.pwr_req[gi]),
                .cnt_en  (bus.cnt_en[gi]),
                .pwr_en  (pwr_en_w[gi]),
                .iso_en  (iso_en_w[gi]),
                .save    (save_w[gi]),
                .restore (restore_w[gi]),
                .pwr_ack (pwr_ack_w[gi]),
                .state   (state_w[gi*STATE_W +: STATE_W]),
                .data    (data_w[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

    assign bus.pwr_en  = pwr_en_w;
    assign bus.iso_en  = iso_en_w;
    assign bus.save    = save_w;
    assign bus.restore = restore_w;
    assign bus.pwr_ack = pwr_ack_w;
    assign bus.state   = state_w;
    assign bus.data    = data_w;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Self-checking bench for pwr_seq_ctrl: directed power scenarios followed by
// random requests, all scored against a sequence-position reference model.
module tb_pwr_seq_ctrl;

    localparam int         NUM_DOM  = 2;
    localparam int         WIDTH    = 8;
    localparam int         RAMP_CYC = 4;
    localparam logic [7:0] ISO_VAL  = 8'h00;

    // Position in the power-up/power-down script: 0 = off, 1..R = ramping,
    // R+1 = restoring, R+2 = on, R+3 = isolating, R+4 = saving.
    localparam int P_REST = RAMP_CYC + 1;
    localparam int P_ON   = RAMP_CYC + 2;
    localparam int P_ISO  = RAMP_CYC + 3;
    localparam int P_SAVE = RAMP_CYC + 4;

    logic clk;
    logic rst;

    pwr_seq_ctrl_if #(.NUM_DOM(NUM_DOM), .WIDTH(WIDTH)) bus ();

    pwr_seq_ctrl #(
        .NUM_DOM  (NUM_DOM),
        .WIDTH    (WIDTH),
        .RAMP_CYC (RAMP_CYC),
        .ISO_VAL  (ISO_VAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec;
    int         n_err;
    int         m_pos  [NUM_DOM];
    logic [7:0] m_live [NUM_DOM];
    logic [7:0] m_ret  [NUM_DOM];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_code(input int p);
        if (p == 0)           return 3'd0;
        else if (p < P_REST)  return 3'd1;
        else if (p == P_REST) return 3'd2;
        else if (p == P_ON)   return 3'd3;
        else if (p == P_ISO)  return 3'd4;
        else                  return 3'd5;
    endfunction

    task automatic model_step();
        for (int d = 0; d < NUM_DOM; d++) begin
            if (rst) begin
                m_pos[d]  = 0;
                m_live[d] = 8'hFF;
                m_ret[d]  = 8'h00;
            end else begin
                int p;
                p = m_pos[d];
                if (p == P_ON && bus.cnt_en[d]) m_live[d] = m_live[d] + 8'd1;
                if (p == P_REST) m_live[d] = m_ret[d];
                if (p == P_SAVE) begin
                    m_ret[d]  = m_live[d];
                    m_live[d] = 8'hFF;
                end
                if (p == 0)          m_pos[d] = bus.pwr_req[d] ? 1 : 0;
                else if (p < P_ON)   m_pos[d] = p + 1;
                else if (p == P_ON)  m_pos[d] = bus.pwr_req[d] ? P_ON : P_ISO;
                else if (p == P_ISO) m_pos[d] = P_SAVE;
                else                 m_pos[d] = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [5:0]  e_state;
        logic [1:0]  e_pwr_en, e_iso, e_save, e_rest, e_ack;
        logic [15:0] e_data;
        logic [2:0]  c;
        for (int d = 0; d < NUM_DOM; d++) begin
            c = exp_code(m_pos[d]);
            e_state[d*3 +: 3] = c;
            e_pwr_en[d]       = (c != 3'd0);
            e_iso[d]          = (c != 3'd3);
            e_save[d]         = (c == 3'd5);
            e_rest[d]         = (c == 3'd2);
            e_ack[d]          = (c == 3'd3);
            e_data[d*8 +: 8]  = e_iso[d] ? ISO_VAL : m_live[d];
        end
        chk("state",   64'(bus.state),   64'(e_state));
        chk("pwr_en",  64'(bus.pwr_en),  64'(e_pwr_en));
        chk("iso_en",  64'(bus.iso_en),  64'(e_iso));
        chk("save",    64'(bus.save),    64'(e_save));
        chk("restore", 64'(bus.restore), 64'(e_rest));
        chk("pwr_ack", 64'(bus.pwr_ack), 64'(e_ack));
        chk("data",    64'(bus.data),    64'(e_data));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        $display("t=%0t rst=%b req=%b en=%b st=%h ack=%b data=%h",
                 $time, rst, bus.pwr_req, bus.cnt_en, bus.state, bus.pwr_ack, bus.data);
    endtask

    task automatic wait_ack(input int d, output int n);
        n = 0;
        while (!bus.pwr_ack[d] && n < 50) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        n_vec = 0;
        n_err = 0;
        for (int d = 0; d < NUM_DOM; d++) begin
            m_pos[d]  = 0;
            m_live[d] = 8'hFF;
            m_ret[d]  = 8'h00;
        end
        rst = 1'b1;
        bus.pwr_req = 2'b11;
        bus.cnt_en  = 2'b00;
        repeat (3) tick();
        chk("rst_state",  64'(bus.state),  64'd0);
        chk("rst_pwr_en", 64'(bus.pwr_en), 64'd0);
        chk("rst_iso",    64'(bus.iso_en), 64'h3);
        chk("rst_data",   64'(bus.data),   64'h0000);

        rst = 1'b0;
        tick();
        chk("rel_pwr_en", 64'(bus.pwr_en), 64'h3);
        bus.pwr_req = 2'b00;
        repeat (12) tick();

        // Domain 0 power-up latency and a single-cycle restore strobe.
        bus.pwr_req = 2'b01;
        tick();
        n = 0;
        cnt = 0;
        while (!bus.pwr_ack[0] && n < 50) begin
            tick();
            n++;
            if (bus.restore[0]) cnt++;
        end
        chk("up_latency",  64'(n),   64'(RAMP_CYC + 1));
        chk("restore_len", 64'(cnt), 64'd1);

        bus.cnt_en = 2'b01;
        repeat (5) tick();
        chk("count5", 64'(bus.data[7:0]), 64'h05);
        bus.cnt_en = 2'b00;

        // Power-down ordering: isolate, save, then drop the supply.
        bus.pwr_req = 2'b00;
        tick();
        chk("dn_iso",     64'(bus.iso_en[0]),  64'd1);
        chk("dn_clamp",   64'(bus.data[7:0]),  64'(ISO_VAL));
        chk("dn_pwr_on",  64'(bus.pwr_en[0]),  64'd1);
        tick();
        chk("dn_save",    64'(bus.save[0]),    64'd1);
        tick();
        chk("dn_pwr_off", 64'(bus.pwr_en[0]),  64'd0);
        chk("dn_save_lo", 64'(bus.save[0]),    64'd0);

        bus.pwr_req = 2'b01;
        tick();
        wait_ack(0, n);
        chk("re_latency", 64'(n),              64'(RAMP_CYC + 1));
        chk("retained",   64'(bus.data[7:0]),  64'h05);
        bus.cnt_en = 2'b01;
        tick();
        chk("retained_inc", 64'(bus.data[7:0]), 64'h06);
        repeat (260) tick();
        chk("wrap", 64'(bus.data[7:0]), 64'h0A);
        bus.cnt_en = 2'b00;

        // Request withdrawn mid-ramp still completes to one cycle of ON.
        bus.pwr_req = 2'b00;
        repeat (3) tick();
        chk("off_again", 64'(bus.state[2:0]), 64'd0);
        bus.pwr_req = 2'b01;
        tick();
        tick();
        bus.pwr_req = 2'b00;
        n = 0;
        cnt = 0;
        while (bus.state[2:0] != 3'd5 && n < 40) begin
            tick();
            n++;
            if (bus.pwr_ack[0]) cnt++;
        end
        chk("abort_ack_pulse", 64'(cnt),            64'd1);
        chk("abort_to_save",   64'(bus.state[2:0]), 64'd5);
        bus.pwr_req = 2'b01;
        tick();
        chk("save_to_off", 64'(bus.state[2:0]), 64'd0);
        tick();
        chk("off_to_ramp", 64'(bus.state[2:0]), 64'd1);
        bus.pwr_req = 2'b00;
        repeat (12) tick();

        // Reset mid-activity wipes retention as well as the live count.
        bus.pwr_req = 2'b10;
        tick();
        wait_ack(1, n);
        chk("d1_latency", 64'(n), 64'(RAMP_CYC + 1));
        bus.pwr_req = 2'b11;
        bus.cnt_en  = 2'b10;
        repeat (3) tick();
        chk("d1_count3",  64'(bus.data[15:8]),  64'h03);
        chk("d0_ramping", 64'(bus.state[2:0]),  64'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_state", 64'(bus.state), 64'd0);
        chk("mid_rst_data",  64'(bus.data),  64'h0000);
        rst = 1'b0;
        bus.pwr_req = 2'b10;
        bus.cnt_en  = 2'b00;
        tick();
        wait_ack(1, n);
        chk("d1_ret_clr", 64'(bus.data[15:8]), 64'h00);

        // Random phase: sticky requests, random enables, rare resets.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int d = 0; d < NUM_DOM; d++) begin
                if ($urandom_range(0, 7) == 0) bus.pwr_req[d] = ~bus.pwr_req[d];
            end
            bus.cnt_en = 2'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
